// File: rtl/serdes_link_if.sv
// Parallel-side bundle of serdes_link: transmit handshake and receive strobes.
// A word moves on a rising clk edge where tx_valid && tx_ready. The source holds
// tx_valid/tx_data stable until that edge. rx_valid/rx_err are single-cycle pulses with no backpressure.
interface serdes_link_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err
  );
endinterface

// File: rtl/serdes_link.sv
// Framed single-wire link: start(1), LSB-first data, optional even parity, stop(0).
// The TX and RX FSMs share one clock; loopback feeds the RX from the local serial_out.
module serdes_link #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                nreset,
  serdes_link_if.slave        bus,
  output logic                serial_out,
  input  logic                serial_in,
  input  logic                loopback,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [2:0]          tx_state_dbg,
  output logic [1:0]          rx_state_dbg
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HUNT   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // ---------------------------------------------------------------- transmit
  tx_state_t         tx_state;
  tx_state_t         tx_state_nxt;
  logic [DATA_W-1:0] tx_shreg;
  logic              tx_par;
  logic [CNT_W-1:0]  tx_cnt;
  logic              tx_accept;

  // Ready in STOP lets the next start bit follow the stop bit with no idle gap.
  assign bus.tx_ready = (tx_state == TX_IDLE) || (tx_state == TX_STOP);
  assign tx_accept    = bus.tx_valid && bus.tx_ready;

  always_comb begin
    tx_state_nxt = tx_state;
    serial_out   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_accept) tx_state_nxt = TX_START;
      end
      TX_START: begin
        serial_out   = 1'b1;
        tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        serial_out = tx_shreg[0];
        if (tx_cnt == LAST_BIT) tx_state_nxt = PARITY_EN ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        serial_out   = tx_par;
        tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        tx_state_nxt = tx_accept ? TX_START : TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_accept) begin
        tx_shreg <= bus.tx_data;
        tx_par   <= ^bus.tx_data;
        tx_cnt   <= '0;
      end else if (tx_state == TX_DATA) begin
        tx_shreg <= tx_shreg >> 1;
        tx_cnt   <= tx_cnt + CNT_W'(1);
      end
    end
  end

  // ----------------------------------------------------------------- receive
  rx_state_t         rx_state;
  rx_state_t         rx_state_nxt;
  logic [DATA_W-1:0] rx_shreg;
  logic [CNT_W-1:0]  rx_cnt;
  logic              rx_par_err;
  logic              rx_bit;
  logic              rx_frame_ok;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_err_q;
  logic [ERRCNT_W-1:0] err_cnt_q;

  assign rx_bit      = loopback ? serial_out : serial_in;
  assign rx_frame_ok = !rx_bit && !rx_par_err;

  // STOP always goes back to HUNT, so a bad stop bit of 1 is never taken as a start bit.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_HUNT: begin
        if (rx_bit) rx_state_nxt = RX_DATA;
      end
      RX_DATA: begin
        if (rx_cnt == LAST_BIT) rx_state_nxt = PARITY_EN ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: rx_state_nxt = RX_STOP;
      RX_STOP:   rx_state_nxt = RX_HUNT;
      default:   rx_state_nxt = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_state   <= RX_HUNT;
      rx_shreg   <= '0;
      rx_cnt     <= '0;
      rx_par_err <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (rx_state)
        RX_HUNT: begin
          rx_cnt     <= '0;
          rx_par_err <= 1'b0;
        end
        RX_DATA: begin
          rx_shreg <= {rx_bit, rx_shreg[DATA_W-1:1]};
          rx_cnt   <= rx_cnt + CNT_W'(1);
        end
        RX_PARITY: begin
          rx_par_err <= rx_bit ^ (^rx_shreg);
        end
        RX_STOP: begin
          // The word is published even on error so the consumer can inspect it.
          rx_data_q  <= rx_shreg;
          rx_valid_q <= rx_frame_ok;
          rx_err_q   <= !rx_frame_ok;
          if (!rx_frame_ok && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;
  assign err_cnt      = err_cnt_q;

  assign tx_state_dbg = tx_state;
  assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_serdes_link.sv
// Directed bench for serdes_link: an 8-bit parity instance and a 16-bit no-parity instance,
// with a scoreboard of expected received words and their arrival cycles.
module tb_serdes_link;

  localparam int F8  = 11;
  localparam int F16 = 18;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serdes_link_if #(.DATA_W(8))  bus8 ();
  serdes_link_if #(.DATA_W(16)) bus16 ();

  logic       sout8, sin8, lb8;
  logic [7:0] ecnt8;
  logic [2:0] txs8;
  logic [1:0] rxs8;
  logic       sout16, sin16, lb16;
  logic [7:0] ecnt16;
  logic [2:0] txs16;
  logic [1:0] rxs16;

  serdes_link #(.DATA_W(8), .PARITY_EN(1'b1), .ERRCNT_W(8)) dut8 (
    .clk(clk), .nreset(nreset), .bus(bus8.slave),
    .serial_out(sout8), .serial_in(sin8), .loopback(lb8),
    .err_cnt(ecnt8), .tx_state_dbg(txs8), .rx_state_dbg(rxs8)
  );

  serdes_link #(.DATA_W(16), .PARITY_EN(1'b0), .ERRCNT_W(8)) dut16 (
    .clk(clk), .nreset(nreset), .bus(bus16.slave),
    .serial_out(sout16), .serial_in(sin16), .loopback(lb16),
    .err_cnt(ecnt16), .tx_state_dbg(txs16), .rx_state_dbg(rxs16)
  );

  // ------------------------------------------------------------ scoreboard
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [8:0]  exp8_q[$];   // {is_err, word}
  int          cyc8_q[$];
  logic [16:0] exp16_q[$];
  int          cyc16_q[$];
  int          acc8;
  int          acc16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0]  e8;
    logic [16:0] e16;
    int          c;
    if (nreset === 1'b1 && (bus8.rx_valid || bus8.rx_err)) begin
      check("rx8_exclusive", 32'(bus8.rx_valid && bus8.rx_err), 32'd0);
      if (exp8_q.size() == 0) check("rx8_unexpected_pulse", 32'd1, 32'd0);
      else begin
        e8 = exp8_q.pop_front();
        c  = cyc8_q.pop_front();
        check("rx8_word", 32'({bus8.rx_err, bus8.rx_data}), 32'(e8));
        check("rx8_cycle", 32'(cyc), 32'(c));
      end
    end
    if (nreset === 1'b1 && (bus16.rx_valid || bus16.rx_err)) begin
      check("rx16_exclusive", 32'(bus16.rx_valid && bus16.rx_err), 32'd0);
      if (exp16_q.size() == 0) check("rx16_unexpected_pulse", 32'd1, 32'd0);
      else begin
        e16 = exp16_q.pop_front();
        c   = cyc16_q.pop_front();
        check("rx16_word", 32'({bus16.rx_err, bus16.rx_data}), 32'(e16));
        check("rx16_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // All drivers are entered on a falling edge and return on a falling edge.
  task automatic send8(input logic [7:0] d, input bit hold);
    int waited = 0;
    bus8.tx_data  = d;
    bus8.tx_valid = 1'b1;
    while (bus8.tx_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("tx8_accept_wait", 32'(bus8.tx_ready), 32'd1);
    acc8 = cyc + 1;
    exp8_q.push_back({1'b0, d});
    cyc8_q.push_back(cyc + 1 + F8);
    @(negedge clk);
    if (!hold) bus8.tx_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] d, input bit hold);
    int waited = 0;
    bus16.tx_data  = d;
    bus16.tx_valid = 1'b1;
    while (bus16.tx_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("tx16_accept_wait", 32'(bus16.tx_ready), 32'd1);
    acc16 = cyc + 1;
    exp16_q.push_back({1'b0, d});
    cyc16_q.push_back(cyc + 1 + F16);
    @(negedge clk);
    if (!hold) bus16.tx_valid = 1'b0;
  endtask

  task automatic drive8(input logic [7:0] d, input bit par_flip, input bit stop);
    logic [10:0] f;
    f = {stop, (^d) ^ par_flip, d, 1'b1};
    exp8_q.push_back({par_flip | stop, d});
    cyc8_q.push_back(cyc + F8);
    for (int k = 0; k < F8; k++) begin
      sin8 = f[k];
      @(negedge clk);
    end
    sin8 = 1'b0;
  endtask

  task automatic drive16(input logic [15:0] d, input bit stop);
    logic [17:0] f;
    f = {stop, d, 1'b1};
    exp16_q.push_back({stop, d});
    cyc16_q.push_back(cyc + F16);
    for (int k = 0; k < F16; k++) begin
      sin16 = f[k];
      @(negedge clk);
    end
    sin16 = 1'b0;
  endtask

  // --------------------------------------------------------------- sequence
  initial begin
    logic [10:0] seq_a5;
    logic [17:0] seq_beef;
    int          a;
    int          waited;

    nreset = 1'b0;
    bus8.tx_data = '0;  bus8.tx_valid = 1'b0;
    bus16.tx_data = '0; bus16.tx_valid = 1'b0;
    sin8 = 1'b0; sin16 = 1'b0; lb8 = 1'b1; lb16 = 1'b1;

    #3;
    check("rst_tx_ready",   32'(bus8.tx_ready), 32'd1);
    check("rst_serial_out", 32'(sout8), 32'd0);
    check("rst_rx_data",    32'(bus8.rx_data), 32'd0);
    check("rst_rx_valid",   32'(bus8.rx_valid), 32'd0);
    check("rst_rx_err",     32'(bus8.rx_err), 32'd0);
    check("rst_err_cnt",    32'(ecnt8), 32'd0);
    check("rst16_tx_ready", 32'(bus16.tx_ready), 32'd1);
    check("rst16_serial",   32'(sout16), 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // 0xA5 in loopback: exact serial waveform and ready profile
    seq_a5 = 11'b00101001011;
    send8(8'hA5, 1'b0);
    for (int i = 0; i < F8; i++) begin
      check("a5_serial_bit", 32'(sout8), 32'(seq_a5[i]));
      check("a5_tx_ready", 32'(bus8.tx_ready), 32'(i == F8 - 1));
      if (i < F8 - 1) @(negedge clk);
    end
    @(negedge clk);
    check("a5_rx_valid", 32'(bus8.rx_valid), 32'd1);
    check("a5_rx_data", 32'(bus8.rx_data), 32'hA5);
    check("a5_err_cnt", 32'(ecnt8), 32'd0);

    // back-to-back with tx_valid held
    send8(8'h01, 1'b1);
    a = acc8;
    send8(8'hFF, 1'b1);
    check("b2b_gap_1", 32'(acc8 - a), 32'(F8));
    a = acc8;
    send8(8'h80, 1'b0);
    check("b2b_gap_2", 32'(acc8 - a), 32'(F8));
    repeat (F8 + 3) @(negedge clk);

    // external line: inverted parity
    lb8 = 1'b0;
    @(negedge clk);
    drive8(8'h3C, 1'b1, 1'b0);
    check("par_rx_err", 32'(bus8.rx_err), 32'd1);
    check("par_rx_valid", 32'(bus8.rx_valid), 32'd0);
    check("par_rx_data", 32'(bus8.rx_data), 32'h3C);
    check("par_err_cnt", 32'(ecnt8), 32'd1);

    // framing error, one idle zero, then a clean frame
    @(negedge clk);
    drive8(8'h55, 1'b0, 1'b1);
    check("frm_rx_err", 32'(bus8.rx_err), 32'd1);
    check("frm_err_cnt", 32'(ecnt8), 32'd2);
    @(negedge clk);
    drive8(8'h0F, 1'b0, 1'b0);
    check("resync_rx_valid", 32'(bus8.rx_valid), 32'd1);
    check("resync_rx_data", 32'(bus8.rx_data), 32'h0F);
    check("resync_err_cnt", 32'(ecnt8), 32'd2);

    // asynchronous reset in the middle of the data bits
    lb8 = 1'b1;
    @(negedge clk);
    send8(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_serial_pre", 32'(sout8), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_serial", 32'(sout8), 32'd0);
    check("mid_rst_ready", 32'(bus8.tx_ready), 32'd1);
    check("mid_rst_rx_data", 32'(bus8.rx_data), 32'd0);
    check("mid_rst_err_cnt", 32'(ecnt8), 32'd0);
    void'(exp8_q.pop_back());
    void'(cyc8_q.pop_back());
    @(negedge clk);
    nreset = 1'b1;
    repeat (F8 + 4) @(negedge clk);
    send8(8'h5A, 1'b0);
    repeat (F8) @(negedge clk);
    check("post_rst_rx_data", 32'(bus8.rx_data), 32'h5A);

    // 16-bit, no parity, loopback
    seq_beef = {1'b0, 16'hBEEF, 1'b1};
    send16(16'hBEEF, 1'b0);
    for (int i = 0; i < F16; i++) begin
      check("beef_serial_bit", 32'(sout16), 32'(seq_beef[i]));
      check("beef_tx_ready", 32'(bus16.tx_ready), 32'(i == F16 - 1));
      if (i < F16 - 1) @(negedge clk);
    end
    @(negedge clk);
    check("beef_rx_valid", 32'(bus16.rx_valid), 32'd1);
    check("beef_rx_data", 32'(bus16.rx_data), 32'hBEEF);

    // error counter saturation
    lb16 = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      drive16(16'($urandom_range(0, 65535)), 1'b1);
      if (n == 99)  check("sat_err_cnt_100", 32'(ecnt16), 32'd100);
      if (n == 254) check("sat_err_cnt_255", 32'(ecnt16), 32'd255);
    end
    check("sat_err_cnt_final", 32'(ecnt16), 32'd255);
    check("sat_err_cnt8_untouched", 32'(ecnt8), 32'd0);

    waited = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", 32'(exp8_q.size() + exp16_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
